// File: rtl/control_unit_if.sv
// Control bundle between control_unit and new_datapath: the instruction register
// flows in; every phase control line flows out.
interface control_unit_if;
   logic [31:0] IR;
   logic        PCout, PCin, IncPC;
   logic        MARin, MDRin, MDRout, Read, write;
   logic        IRin, Yin, Zin, Zloout;
   logic        Zhiout, HIin, HIout, LOin, LOout;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic        Cout;
   logic [4:0]  ALUControl;
   logic        Run;

   modport master (
      input  IR,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, write,
             IRin, Yin, Zin, Zloout, Zhiout, HIin, HIout, LOin, LOout,
             Gra, Grb, Grc, Rin, Rout, BAout, Cout, ALUControl, Run
   );

   modport slave (
      output IR,
      input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, write,
             IRin, Yin, Zin, Zloout, Zhiout, HIin, HIout, LOin, LOout,
             Gra, Grb, Grc, Rin, Rout, BAout, Cout, ALUControl, Run
   );
endinterface

// File: rtl/control_unit.sv
// Hard-wired phase sequencer: fetch in T0-T2, opcode-decoded execute in T3-T7.
// Control lines are a pure function of (phase, IR[31:27]).
module control_unit (
   input  logic           Clock,
   input  logic           GlobalReset,
   control_unit_if.master cu
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_e     state_q, state_d;
   logic [4:0] opcode;
   logic       is_mem, is_rtype, is_imm;
   logic [4:0] imm_alu;

   assign opcode   = cu.IR[31:27];
   assign is_mem   = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
   assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
   assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

   // Immediate forms reuse the R-type ALU codes of their register counterparts.
   always_comb begin
      case (opcode)
         OP_ANDI: imm_alu = OP_AND;
         OP_ORI:  imm_alu = OP_OR;
         default: imm_alu = OP_ADD;
      endcase
   end

   // NOTE: state flops use non-blocking assignment so every reader sees the pre-edge value.
   always_ff @(posedge Clock or posedge GlobalReset) begin
      if (GlobalReset) state_q <= S_RESET;
      else             state_q <= state_d;
   end

   // NOTE: every output and state_d gets a default first, so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      cu.PCout      = 1'b0;
      cu.PCin       = 1'b0;
      cu.IncPC      = 1'b0;
      cu.MARin      = 1'b0;
      cu.MDRin      = 1'b0;
      cu.MDRout     = 1'b0;
      cu.Read       = 1'b0;
      cu.write      = 1'b0;
      cu.IRin       = 1'b0;
      cu.Yin        = 1'b0;
      cu.Zin        = 1'b0;
      cu.Zloout     = 1'b0;
      cu.Zhiout     = 1'b0;
      cu.HIin       = 1'b0;
      cu.HIout      = 1'b0;
      cu.LOin       = 1'b0;
      cu.LOout      = 1'b0;
      cu.Gra        = 1'b0;
      cu.Grb        = 1'b0;
      cu.Grc        = 1'b0;
      cu.Rin        = 1'b0;
      cu.Rout       = 1'b0;
      cu.BAout      = 1'b0;
      cu.Cout       = 1'b0;
      cu.ALUControl = 5'b00000;
      cu.Run        = (state_q != S_RESET) && (state_q != S_HALT);

      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0: begin
            cu.PCout = 1'b1;
            cu.MARin = 1'b1;
            cu.IncPC = 1'b1;
            cu.PCin  = 1'b1;
            state_d  = S_T1;
         end
         S_T1: begin
            cu.Read  = 1'b1;
            cu.MDRin = 1'b1;
            state_d  = S_T2;
         end
         S_T2: begin
            cu.MDRout = 1'b1;
            cu.IRin   = 1'b1;
            state_d   = S_T3;
         end
         S_T3: begin
            if (is_mem) begin
               cu.Grb   = 1'b1;
               cu.BAout = 1'b1;
               cu.Yin   = 1'b1;
               state_d  = S_T4;
            end else if (is_rtype || is_imm) begin
               cu.Grb  = 1'b1;
               cu.Rout = 1'b1;
               cu.Yin  = 1'b1;
               state_d = S_T4;
            end else if (opcode == OP_HALT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_T0;
            end
         end
         S_T4: begin
            cu.Zin  = 1'b1;
            state_d = S_T5;
            if (is_rtype) begin
               cu.Grc        = 1'b1;
               cu.Rout       = 1'b1;
               cu.ALUControl = opcode;
            end else if (is_imm) begin
               cu.Cout       = 1'b1;
               cu.ALUControl = imm_alu;
            end else begin
               // ld/ldi/st: effective address / immediate = base + C
               cu.Cout       = 1'b1;
               cu.ALUControl = OP_ADD;
            end
         end
         S_T5: begin
            cu.Zloout = 1'b1;
            if ((opcode == OP_LD) || (opcode == OP_ST)) begin
               cu.MARin = 1'b1;
               state_d  = S_T6;
            end else begin
               cu.Gra  = 1'b1;
               cu.Rin  = 1'b1;
               state_d = S_T0;
            end
         end
         S_T6: begin
            cu.MDRin = 1'b1;
            state_d  = S_T7;
            // Store loads MDR from the bus: Read stays low to select the bus side.
            if (opcode == OP_ST) begin
               cu.Gra  = 1'b1;
               cu.Rout = 1'b1;
            end else begin
               cu.Read = 1'b1;
            end
         end
         S_T7: begin
            state_d = S_T0;
            if (opcode == OP_ST) begin
               cu.write = 1'b1;
            end else begin
               cu.MDRout = 1'b1;
               cu.Gra    = 1'b1;
               cu.Rin    = 1'b1;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

endmodule
